// File: rtl/logit_argmax_reader_pkg.sv
// rtl/logit_argmax_reader_pkg.sv - shared logit geometry, logit type and FSM encodings
package logit_argmax_reader_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int LOGIT_W     = 6;
  localparam int IDX_W       = 4;

  typedef logic signed [LOGIT_W-1:0] logit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logit_argmax_reader.sv
// rtl/logit_argmax_reader.sv - sequential argmax/runner-up scan over a producer's logit read port
module logit_argmax_reader #(
  parameter int NUM_CLASSES = logit_argmax_reader_pkg::NUM_CLASSES,
  parameter int LOGIT_W     = logit_argmax_reader_pkg::LOGIT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [3:0]                read_addr,
  input  logic signed [LOGIT_W-1:0] read_data,
  output logic                      busy,
  output logic                      valid,
  output logic [3:0]                class_idx,
  output logic signed [LOGIT_W-1:0] max_logit,
  output logic [LOGIT_W:0]          margin
);
  import logit_argmax_reader_pkg::*;

  localparam logic [3:0] LAST_K = 4'(NUM_CLASSES - 1);
  localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [3:0]                r_cnt;
  logic                      r_fin;
  logic signed [LOGIT_W-1:0] r_max;
  logic signed [LOGIT_W-1:0] r_sec;
  logic [3:0]                r_idx;
  logic signed [LOGIT_W-1:0] w_max_nxt;
  logic signed [LOGIT_W-1:0] w_sec_nxt;
  logic [3:0]                w_idx_nxt;
  logic [LOGIT_W:0]          w_margin;
  logic                      r_busy;
  logic                      r_valid;
  logic [3:0]                r_class_idx;
  logic signed [LOGIT_W-1:0] r_max_logit;
  logic [LOGIT_W:0]          r_margin;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_SCAN;
      ST_SCAN: if (r_fin) w_state_nxt = ST_DONE;
      ST_DONE: if (!start) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strict greater-than keeps the earliest index on ties; an equal value
  // still lands in the runner-up slot so a tied top pair gives margin 0.
  always_comb begin
    w_max_nxt = r_max;
    w_sec_nxt = r_sec;
    w_idx_nxt = r_idx;
    if (r_cnt == 4'd0) begin
      w_max_nxt = read_data;
      w_sec_nxt = LOGIT_MIN;
      w_idx_nxt = 4'd0;
    end else if (read_data > r_max) begin
      w_sec_nxt = r_max;
      w_max_nxt = read_data;
      w_idx_nxt = r_cnt;
    end else if (read_data > r_sec) begin
      w_sec_nxt = read_data;
    end
  end

  // max >= second always holds, so the widened difference is non-negative.
  assign w_margin = {r_max[LOGIT_W-1], r_max} - {r_sec[LOGIT_W-1], r_sec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_fin       <= 1'b0;
      r_max       <= '0;
      r_sec       <= '0;
      r_idx       <= 4'd0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_class_idx <= 4'd0;
      r_max_logit <= '0;
      r_margin    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= 4'd0;
            r_fin   <= 1'b0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (!r_fin) begin
            r_max <= w_max_nxt;
            r_sec <= w_sec_nxt;
            r_idx <= w_idx_nxt;
            if (r_cnt == LAST_K) begin
              r_fin <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_class_idx <= r_idx;
            r_max_logit <= r_max;
            r_margin    <= w_margin;
            r_valid     <= 1'b1;
            r_busy      <= 1'b0;
            r_fin       <= 1'b0;
            r_cnt       <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_addr = (r_state == ST_SCAN) ? r_cnt : 4'd0;
  assign busy      = r_busy;
  assign valid     = r_valid;
  assign class_idx = r_class_idx;
  assign max_logit = r_max_logit;
  assign margin    = r_margin;

endmodule

// File: tb/tb_logit_argmax_reader.sv
// tb/tb_logit_argmax_reader.sv - self-checking bench for logit_argmax_reader
module tb_logit_argmax_reader;

  localparam int N = 10;
  localparam int W = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [3:0]          read_addr;
  logic signed [W-1:0] read_data;
  logic                busy;
  logic                valid;
  logic [3:0]          class_idx;
  logic signed [W-1:0] max_logit;
  logic [W:0]          margin;

  logic signed [W-1:0] mem [N];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb read_data = (read_addr < 4'(N)) ? mem[read_addr] : '0;

  logit_argmax_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .read_addr (read_addr),
    .read_data (read_data),
    .busy      (busy),
    .valid     (valid),
    .class_idx (class_idx),
    .max_logit (max_logit),
    .margin    (margin)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: first index holding the maximum; runner-up is the largest of the rest.
  task automatic ref_model(output int idx, output int mx, output int mg);
    int sec;
    mx  = int'(mem[0]);
    idx = 0;
    for (int i = 1; i < N; i++) begin
      if (int'(mem[i]) > mx) begin
        mx  = int'(mem[i]);
        idx = i;
      end
    end
    sec = -(1 << (W - 1));
    for (int i = 0; i < N; i++) begin
      if (i != idx && int'(mem[i]) > sec) sec = int'(mem[i]);
    end
    mg = mx - sec;
  endtask

  task automatic chk_result(input string tag);
    int ei, emx, emg;
    ref_model(ei, emx, emg);
    chk({tag, ":class_idx"}, 32'(class_idx), ei);
    chk({tag, ":max_logit"}, 32'(max_logit), emx);
    chk({tag, ":margin"}, 32'(margin), emg);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":busy"}, 32'(busy), 0);
    chk({tag, ":valid"}, 32'(valid), 0);
    chk({tag, ":class_idx"}, 32'(class_idx), 0);
    chk({tag, ":max_logit"}, 32'(max_logit), 0);
    chk({tag, ":margin"}, 32'(margin), 0);
    chk({tag, ":read_addr"}, 32'(read_addr), 0);
  endtask

  task automatic scan(input bit hold, input bit jitter, input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ":busy_e0"}, 32'(busy), 1);
    chk({tag, ":valid_e0"}, 32'(valid), 0);
    for (int k = 0; k < N; k++) begin
      chk({tag, ":read_addr_k"}, 32'(read_addr), k);
      chk({tag, ":valid_scan"}, 32'(valid), 0);
      if (jitter) start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk({tag, ":valid_e10"}, 32'(valid), 0);
    chk({tag, ":busy_e10"}, 32'(busy), 1);
    @(posedge clk);
    #1;
    chk({tag, ":valid_e11"}, 32'(valid), 1);
    chk({tag, ":busy_e11"}, 32'(busy), 0);
    chk({tag, ":read_addr_done"}, 32'(read_addr), 0);
    chk_result(tag);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, ":valid_idle"}, 32'(valid), 1);
      chk({tag, ":read_addr_idle"}, 32'(read_addr), 0);
      chk_result({tag, ":idle"});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_reset:busy", 32'(busy), 0);
      chk("post_reset:read_addr", 32'(read_addr), 0);
    end

    mem = '{6'sd3, -6'sd1, 6'sd7, 6'sd2, 6'sd0, -6'sd5, 6'sd6, 6'sd1, -6'sd2, 6'sd4};
    scan(1'b0, 1'b0, "vec_basic");
    chk("vec_basic:idx_const", 32'(class_idx), 2);
    chk("vec_basic:margin_const", 32'(margin), 1);

    for (int i = 0; i < N; i++) mem[i] = -6'sd32;
    scan(1'b0, 1'b0, "all_min");
    chk("all_min:max_const", 32'(max_logit), -32);

    for (int i = 0; i < N; i++) mem[i] = 6'sd0;
    mem[4] = 6'sd31;
    mem[8] = 6'sd31;
    scan(1'b0, 1'b0, "tie_top");
    chk("tie_top:idx_const", 32'(class_idx), 4);
    chk("tie_top:margin_const", 32'(margin), 0);

    for (int i = 0; i < N; i++) mem[i] = -6'sd32;
    mem[9] = 6'sd31;
    scan(1'b1, 1'b0, "last_max");
    chk("last_max:margin_const", 32'(margin), 63);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("held_start:busy", 32'(busy), 0);
      chk("held_start:valid", 32'(valid), 1);
      chk("held_start:read_addr", 32'(read_addr), 0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    for (int i = 0; i < N; i++) mem[i] = 6'($urandom);
    scan(1'b0, 1'b0, "rescan");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        mem[i] = (r % 2 == 0) ? 6'($urandom) : 6'($urandom_range(0, 4) - 2);
      end
      scan(1'b0, 1'b1, "random");
    end

    for (int i = 0; i < N; i++) mem[i] = 6'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("mid_scan:read_addr", 32'(read_addr), 5);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("after_reset:busy", 32'(busy), 0);
      chk("after_reset:valid", 32'(valid), 0);
    end
    for (int i = 0; i < N; i++) mem[i] = 6'($urandom);
    scan(1'b0, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logit_argmax_reader.md
LOGIT_ARGMAX_READER -- requirements
Module: logit_argmax_reader

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of logits scanned (addresses 0..NUM_CLASSES-1).
REQ-002 Parameter LOGIT_W, default 6, signed two's-complement logit width.
REQ-003 One clock; reset is asynchronous and active-low: clk, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level request, driven by the logit producer's done flag.
REQ-007 read_addr  output  4  logit index presented to the producer's read port.
REQ-008 read_data  input  LOGIT_W signed; the producer's combinational response to read_addr in the same cycle.
REQ-009 busy  output  1  scan in progress.
REQ-010 valid  output  1  class_idx, max_logit and margin hold a completed result.
REQ-011 class_idx  output  4  index of the largest logit.
REQ-012 max_logit  output  LOGIT_W signed  value of the largest logit.
REQ-013 margin  output  LOGIT_W+1 unsigned  max_logit minus the runner-up logit.

Function
REQ-014 FSM states SHALL be IDLE, SCAN and DONE; encoding is taken from the package.
REQ-015 In IDLE with start=1, the next edge SHALL enter SCAN, clear the scan counter to 0, set busy=1 and clear valid.
REQ-016 In SCAN, read_addr SHALL equal the scan counter k, and read_data SHALL be sampled at the edge ending that cycle, one logit per cycle.
REQ-017 At k=0: running max = read_data, idx = 0, running second = most-negative value (-32 for LOGIT_W=6).
REQ-018 At k>0: if read_data > max (strict), then second <= max, max <= read_data, idx <= k; else if read_data > second, then second <= read_data.
REQ-019 Ties SHALL resolve to the lowest index; an equal top pair SHALL yield margin 0.
REQ-020 All comparisons SHALL be signed; margin SHALL be computed in LOGIT_W+1 bits and lie in 0..2^LOGIT_W-1.
REQ-021 After sampling k=NUM_CLASSES-1, the next edge SHALL register the outputs, set valid=1 and busy=0, and enter DONE.
REQ-022 Latency: start accepted at edge E0; valid SHALL rise at edge E0+NUM_CLASSES+1 (E0+11 for the default).
REQ-023 In DONE, the block SHALL stay until start=0, then return to IDLE; a start held high SHALL NOT retrigger a scan.
REQ-024 valid and the result outputs SHALL hold from DONE through IDLE until the next accepted start clears valid.
REQ-025 read_addr SHALL be 0 in IDLE and DONE.
REQ-026 start changes during SCAN SHALL be ignored.
REQ-027 The scan counter SHALL never exceed NUM_CLASSES-1.
REQ-028 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-029 On rst_n=0, at any time including mid-scan: state=IDLE, busy=0, valid=0, class_idx=0, max_logit=0, margin=0, read_addr=0, counter=0; a partial scan SHALL be discarded.
REQ-030 Reset release SHALL NOT itself start a scan; it requires start=1 sampled in IDLE.

Structure
REQ-031 A shared package SHALL hold NUM_CLASSES, LOGIT_W, the logit signed type and the FSM state encodings, for reuse by the producer side and the top level.
REQ-032 No sub-module: the compare/update datapath is inline, a single flat module of roughly 150 lines.

Verification
REQ-033 Logits [3,-1,7,2,0,-5,6,1,-2,4], start pulse -> valid at E0+11, class_idx=2, max_logit=7, margin=1.
REQ-034 All logits=-32 -> class_idx=0, max_logit=-32, margin=0.
REQ-035 Logits with 31 at indices 4 and 8, all others 0 -> class_idx=4, margin=0.
REQ-036 Logit 9 =31, all others -32 -> class_idx=9, margin=63; start held high 20 cycles after DONE -> exactly one scan; drop then raise start -> second scan, valid low during busy.
REQ-037 rst_n asserted at k=5 -> all outputs 0 immediately; no valid until a new start completes a full 10-cycle scan.
REQ-038 Bench model checks read_addr equals k on each SCAN cycle and equals 0 otherwise.
